// File: rtl/dvp_tx.sv
// DVP video transmitter: turns a 16-bit RGB565 valid/ready pixel stream into
// vsync/href/8-bit data with programmable frame timing. Each pixel occupies
// two byte clocks, high byte first. All DVP pins are registered and lag the
// frame counters by one clock.
module dvp_tx #(
   parameter int          ACTIVE_IW = 640,
   parameter int          ACTIVE_IH = 480,
   parameter int          TOTAL_HW  = 1600,
   parameter int          TOTAL_IH  = 600,
   parameter int          H_START   = 100,
   parameter int          V_START   = 30,
   parameter int          VS_LINES  = 3,
   parameter logic [15:0] FILL      = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic        clr_underrun,
   output logic        vsync,
   output logic        href,
   output logic [7:0]  data,
   output logic        frame_done,
   output logic        underrun,
   output logic        busy
);

   localparam int HW    = $clog2(TOTAL_HW);
   localparam int VW    = $clog2(TOTAL_IH);
   localparam int H_END = H_START + 2 * ACTIVE_IW;
   localparam int V_END = V_START + ACTIVE_IH;

   localparam logic [HW-1:0] H_LAST = HW'(TOTAL_HW - 1);
   localparam logic [VW-1:0] V_LAST = VW'(TOTAL_IH - 1);
   localparam logic [HW-1:0] H_ZERO = {HW{1'b0}};
   localparam logic [VW-1:0] V_ZERO = {VW{1'b0}};
   localparam logic [HW-1:0] H_ONE  = {{(HW-1){1'b0}}, 1'b1};
   localparam logic [VW-1:0] V_ONE  = {{(VW-1){1'b0}}, 1'b1};
   // LSB of h_cnt that marks the first byte (high byte) of a pixel slot
   localparam logic HS_LSB = ((H_START % 2) != 0);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state_r, state_nxt_s;
   logic [HW-1:0] h_cnt_r, h_nxt_s;
   logic [VW-1:0] v_cnt_r, v_nxt_s;

   logic          vsync_r, href_r, frame_done_r, underrun_r;
   logic [7:0]    data_r, lo_byte_r;

   logic [31:0]   h_ext_s, v_ext_s;
   logic          run_s, h_last_s, v_last_s;
   logic          line_act_s, active_s, hi_slot_s, vs_line_s, fd_nxt_s;
   logic [15:0]   pix_sel_s;

   assign h_ext_s    = 32'(h_cnt_r);
   assign v_ext_s    = 32'(v_cnt_r);
   assign run_s      = (state_r == RUN);
   assign h_last_s   = (h_cnt_r == H_LAST);
   assign v_last_s   = (v_cnt_r == V_LAST);
   assign line_act_s = (v_ext_s >= 32'(V_START)) && (v_ext_s < 32'(V_END));
   assign active_s   = run_s && line_act_s &&
                       (h_ext_s >= 32'(H_START)) && (h_ext_s < 32'(H_END));
   assign hi_slot_s  = active_s && (h_cnt_r[0] == HS_LSB);
   assign vs_line_s  = run_s && (v_ext_s < 32'(VS_LINES));
   // An empty source still yields a pixel slot; it is filled with FILL
   assign pix_sel_s  = pix_valid ? pix_data : FILL;
   // frame_done is registered one clock ahead so it coincides with the last counter state
   assign fd_nxt_s   = (state_nxt_s == RUN) && (h_nxt_s == H_LAST) && (v_nxt_s == V_LAST);

   assign pix_ready  = hi_slot_s;
   assign vsync      = vsync_r;
   assign href       = href_r;
   assign data       = data_r;
   assign frame_done = frame_done_r;
   assign underrun   = underrun_r;
   assign busy       = run_s;

   // Next-state and counter logic; en is only honoured at frame boundaries
   always_comb begin
      state_nxt_s = state_r;
      h_nxt_s     = h_cnt_r;
      v_nxt_s     = v_cnt_r;
      case (state_r)
         IDLE: begin
            h_nxt_s = H_ZERO;
            v_nxt_s = V_ZERO;
            if (en) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (h_last_s) begin
               h_nxt_s = H_ZERO;
               if (v_last_s) begin
                  v_nxt_s     = V_ZERO;
                  state_nxt_s = en ? RUN : IDLE;
               end else begin
                  v_nxt_s = v_cnt_r + V_ONE;
               end
            end else begin
               h_nxt_s = h_cnt_r + H_ONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            h_nxt_s     = H_ZERO;
            v_nxt_s     = V_ZERO;
         end
      endcase
   end

   // State and frame counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         h_cnt_r <= H_ZERO;
         v_cnt_r <= V_ZERO;
      end else begin
         state_r <= state_nxt_s;
         h_cnt_r <= h_nxt_s;
         v_cnt_r <= v_nxt_s;
      end
   end

   // Registered DVP pins: hi byte on the taken slot, held lo byte on the next
   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_r      <= 1'b0;
         href_r       <= 1'b0;
         data_r       <= 8'h00;
         lo_byte_r    <= 8'h00;
         frame_done_r <= 1'b0;
      end else begin
         vsync_r      <= vs_line_s;
         href_r       <= active_s;
         frame_done_r <= fd_nxt_s;
         if (hi_slot_s) begin
            data_r    <= pix_sel_s[15:8];
            lo_byte_r <= pix_sel_s[7:0];
         end else if (active_s) begin
            data_r    <= lo_byte_r;
         end else begin
            data_r    <= 8'h00;
         end
      end
   end

   // Sticky underrun flag; a new underrun wins over a simultaneous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         underrun_r <= 1'b0;
      end else if (hi_slot_s && !pix_valid) begin
         underrun_r <= 1'b1;
      end else if (clr_underrun) begin
         underrun_r <= 1'b0;
      end else begin
         underrun_r <= underrun_r;
      end
   end

endmodule

// File: tb/tb_dvp_tx.sv
// Self-checking bench for dvp_tx with small frame parameters. A frame-position
// model predicts every pin each cycle; a capture path reassembles the DVP byte
// stream into pixels and compares them with the pixels the model says were sent.
module tb_dvp_tx;

   localparam int IW    = 4;
   localparam int IH    = 2;
   localparam int THW   = 16;
   localparam int TIH   = 5;
   localparam int HS    = 3;
   localparam int VS    = 2;
   localparam int VSL   = 1;
   localparam int FRAME = THW * TIH;
   localparam int DROP_POS = VS * THW + HS + 2;   // 2nd pixel of line 2

   logic        clk = 1'b0;
   logic        rst, en, pix_valid, clr_underrun;
   logic [15:0] pix_data;
   logic        pix_ready, vsync, href, frame_done, underrun, busy;
   logic [7:0]  data;

   always #5 clk = ~clk;

   dvp_tx #(
      .ACTIVE_IW(IW), .ACTIVE_IH(IH), .TOTAL_HW(THW), .TOTAL_IH(TIH),
      .H_START(HS), .V_START(VS), .VS_LINES(VSL), .FILL(16'h0000)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .pix_data(pix_data), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .clr_underrun(clr_underrun), .vsync(vsync), .href(href),
      .data(data), .frame_done(frame_done), .underrun(underrun), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   // model state
   bit          m_run;
   int          m_pos;
   bit          m_unr;
   logic [15:0] m_pix;
   bit          e_vsync, e_href, e_fd;
   logic [7:0]  e_data;

   // source, capture and statistics
   int          src_idx;
   int          cycle;
   logic [15:0] sent_q[$];
   logic [7:0]  first_bytes[$];
   bit          have_hi;
   logic [7:0]  cap_hi;
   bit          stat_on;
   int          fd_prev;
   int          n_vs, n_hr, n_hs;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit slot_active(input int pos);
      int line, col;
      line = pos / THW;
      col  = pos % THW;
      return (line >= VS) && (line < VS + IH) && (col >= HS) && (col < HS + 2 * IW);
   endfunction

   // one clock: check pix_ready, advance model over the edge, check pins
   task automatic step();
      bit rdy, was_act, dut_hs;
      int k;
      rdy = m_run && slot_active(m_pos) && ((((m_pos % THW) - HS) % 2) == 0);
      @(negedge clk);
      chk("pix_ready", pix_ready, rdy);
      dut_hs = pix_ready && pix_valid;
      @(posedge clk);
      if (rst) begin
         m_run = 0; m_pos = 0; m_unr = 0;
         e_vsync = 0; e_href = 0; e_fd = 0; e_data = 8'h00;
         sent_q.delete();
         have_hi = 0;
      end else begin
         was_act = m_run && slot_active(m_pos);
         k = (m_pos % THW) - HS;
         e_vsync = m_run && ((m_pos / THW) < VSL);
         e_href  = was_act;
         if (rdy) begin
            m_pix = pix_valid ? pix_data : 16'h0000;
            sent_q.push_back(m_pix);
            if (pix_valid) src_idx++;
         end
         if (!was_act) e_data = 8'h00;
         else if ((k % 2) == 0) e_data = m_pix[15:8];
         else e_data = m_pix[7:0];
         if (rdy && !pix_valid) m_unr = 1;
         else if (clr_underrun) m_unr = 0;
         if (!m_run) begin
            if (en) begin m_run = 1; m_pos = 0; end
         end else if (m_pos == FRAME - 1) begin
            m_pos = 0;
            m_run = en;
         end else begin
            m_pos++;
         end
         e_fd = m_run && (m_pos == FRAME - 1);
      end
      #1;
      cycle++;
      chk("vsync", vsync, e_vsync);
      chk("href", href, e_href);
      chk("data", data, e_data);
      chk("frame_done", frame_done, e_fd);
      chk("underrun", underrun, m_unr);
      chk("busy", busy, m_run);
      // round trip: reassemble pixels from the DVP byte stream
      if (href) begin
         if (stat_on && first_bytes.size() < 4) first_bytes.push_back(data);
         if (have_hi) begin
            have_hi = 0;
            if (sent_q.size() == 0) begin
               chk("roundtrip_extra", {cap_hi, data}, 32'hFFFF_FFFF);
            end else begin
               chk("roundtrip", {cap_hi, data}, sent_q.pop_front());
            end
         end else begin
            cap_hi  = data;
            have_hi = 1;
         end
      end
      // per-frame statistics between consecutive frame_done pulses
      if (frame_done) begin
         if (stat_on && fd_prev >= 0) begin
            chk("fd_period", cycle - fd_prev, FRAME);
            chk("vsync_clks", n_vs, THW * VSL);
            chk("href_clks", n_hr, 2 * IW * IH);
            chk("handshakes", n_hs, IW * IH);
         end
         fd_prev = cycle;
         n_vs = 0; n_hr = 0; n_hs = 0;
      end
      if (vsync) n_vs++;
      if (href)  n_hr++;
      if (dut_hs) n_hs++;
      pix_data = 16'hA000 + 16'(src_idx);
   endtask

   // run until the model reaches DROP_POS, withhold valid there, check fill bytes
   task automatic do_drop(input bit with_clr);
      bit done;
      done = 0;
      for (int i = 0; i < 3 * FRAME && !done; i++) begin
         pix_valid    = !(m_run && m_pos == DROP_POS);
         clr_underrun = with_clr && !pix_valid;
         step();
         if (!pix_valid) begin
            done = 1;
            chk("fill_hi", data, 8'h00);
            pix_valid    = 1'b1;
            clr_underrun = 1'b0;
            step();
            chk("fill_lo", data, 8'h00);
            chk("underrun_set", underrun, 1'b1);
         end
      end
      pix_valid    = 1'b1;
      clr_underrun = 1'b0;
      if (!done) chk("drop_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      bit seen;
      rst = 1'b1; en = 1'b0; pix_valid = 1'b1; clr_underrun = 1'b0;
      src_idx = 1; pix_data = 16'hA001;
      m_run = 0; m_pos = 0; m_unr = 0; m_pix = 16'h0000;
      e_vsync = 0; e_href = 0; e_fd = 0; e_data = 8'h00;
      cycle = 0; have_hi = 0; stat_on = 0; fd_prev = -1;
      n_vs = 0; n_hr = 0; n_hs = 0;

      // 1: reset, then idle with en=0
      @(posedge clk);
      #1;
      chk("rst_vsync", vsync, 1'b0);
      chk("rst_href", href, 1'b0);
      chk("rst_data", data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_fd", frame_done, 1'b0);
      chk("rst_underrun", underrun, 1'b0);
      step(); step();
      rst = 1'b0;
      for (int i = 0; i < 50; i++) step();

      // 2: continuous frames with an always-valid source
      src_idx = 1; pix_data = 16'hA001;
      stat_on = 1; fd_prev = -1;
      en = 1'b1;
      for (int i = 0; i < 3 * FRAME + 10; i++) step();
      stat_on = 0;
      if (first_bytes.size() == 4) begin
         chk("byte0", first_bytes[0], 8'hA0);
         chk("byte1", first_bytes[1], 8'h01);
         chk("byte2", first_bytes[2], 8'hA0);
         chk("byte3", first_bytes[3], 8'h02);
      end else begin
         chk("first_bytes_count", first_bytes.size(), 4);
      end

      // 3: underrun on the 2nd pixel of line 2, sticky, then cleared
      do_drop(1'b0);
      for (int i = 0; i < 20; i++) step();
      chk("underrun_sticky", underrun, 1'b1);
      clr_underrun = 1'b1;
      step();
      clr_underrun = 1'b0;
      chk("underrun_clr", underrun, 1'b0);

      // 4: clear in the same cycle as a new underrun
      do_drop(1'b1);
      step();
      chk("set_beats_clr", underrun, 1'b1);
      clr_underrun = 1'b1;
      step();
      clr_underrun = 1'b0;

      // 5: drop en mid-frame; frame completes, then idle
      en = 1'b0;
      seen = 0;
      for (int i = 0; i < 2 * FRAME && !seen; i++) begin
         step();
         if (frame_done) seen = 1;
      end
      chk("en_drop_fd_seen", seen, 1'b1);
      step(); step();
      chk("idle_busy", busy, 1'b0);
      chk("idle_vsync", vsync, 1'b0);
      chk("idle_href", href, 1'b0);
      chk("idle_data", data, 8'h00);
      for (int i = 0; i < 10; i++) step();

      // 6: reset at line 2, h=5 with en held
      en = 1'b1;
      seen = 0;
      for (int i = 0; i < 2 * FRAME && !seen; i++) begin
         if (m_run && m_pos == VS * THW + 5) seen = 1;
         else step();
      end
      chk("reach_line2_h5", seen, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_href", href, 1'b0);
      chk("midrst_data", data, 8'h00);
      chk("midrst_vsync", vsync, 1'b0);
      step();
      chk("restart_busy", busy, 1'b1);
      step();
      chk("restart_vsync", vsync, 1'b1);
      for (int i = 0; i < FRAME + 10; i++) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
